// File: rtl/apb_cmd_master.sv
// apb_cmd_master: command/response to APB master bridge; define APB_TIMEOUT_EN to compile in the ACCESS watchdog
module apb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] paddr,
  output logic        wr_en,
  output logic        psel,
  output logic        pen,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pselverr
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t      r_state;
  logic        r_cmd_ready;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [31:0] r_paddr;
  logic        r_wr_en;
  logic        r_psel;
  logic        r_pen;
  logic [31:0] r_pwdata;
`ifdef APB_TIMEOUT_EN
  logic        r_rsp_timeout;
  logic [7:0]  r_cnt;
  // watchdog: counts stalled ACCESS cycles, aborts the transfer when the limit is reached
  always_ff @(posedge clk)
    if (rst || r_state != ACCESS || pready) begin
      r_cnt         <= 8'd0;
      r_rsp_timeout <= (rst || (r_state == RESP && rsp_ready)) ? 1'b0 : r_rsp_timeout;
    end else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
      r_cnt         <= 8'd0;
      r_rsp_timeout <= 1'b1;
    end else
      r_cnt <= r_cnt + 8'd1;
  assign rsp_timeout = r_rsp_timeout;
  wire w_abort = r_state == ACCESS && !pready && r_cnt == 8'(TIMEOUT_CYCLES - 1);
`else
  assign rsp_timeout = 1'b0;
  wire w_abort = 1'b0;
`endif
  // main FSM: every output is a register updated on the state transition that defines it
  always_ff @(posedge clk)
    if (rst) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_paddr     <= 32'd0;
      r_wr_en     <= 1'b0;
      r_psel      <= 1'b0;
      r_pen       <= 1'b0;
      r_pwdata    <= 32'd0;
    end else
      case (r_state)
        IDLE:
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready <= 1'b0;
            if (cmd_addr[1:0] != 2'b00) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'd0;
            end else begin
              r_state  <= SETUP;
              r_psel   <= 1'b1;
              r_paddr  <= cmd_addr;
              r_wr_en  <= cmd_write;
              r_pwdata <= cmd_write ? cmd_wdata : 32'd0;
            end
          end else
            r_cmd_ready <= 1'b1;
        SETUP: begin
          r_state <= ACCESS;
          r_pen   <= 1'b1;
        end
        ACCESS:
          if (pready || w_abort) begin
            r_state     <= RESP;
            r_psel      <= 1'b0;
            r_pen       <= 1'b0;
            r_paddr     <= 32'd0;
            r_wr_en     <= 1'b0;
            r_pwdata    <= 32'd0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= pready ? pselverr : 1'b1;
            r_rsp_rdata <= (!pready || r_wr_en || pselverr) ? 32'd0 : prdata;
          end
        RESP:
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
          end
        default: r_state <= IDLE;
      endcase
  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign paddr     = r_paddr;
  assign wr_en     = r_wr_en;
  assign psel      = r_psel;
  assign pen       = r_pen;
  assign pwdata    = r_pwdata;
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed self-checking bench for apb_cmd_master
module tb_apb_cmd_master;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        wr_en, psel, pen, pready, pselverr;
  int          n_chk = 0;
  int          n_fail = 0;
  apb_cmd_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .wr_en(wr_en), .psel(psel), .pen(pen), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pselverr(pselverr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
    cmd_write = ~w;
    cmd_addr  = 32'hFFFF_FFF0;
    cmd_wdata = 32'h0BAD_0BAD;
  endtask
  task automatic release_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("release cmd_ready", 32'(cmd_ready), 32'd1);
    chk("release rsp_valid", 32'(rsp_valid), 32'd0);
  endtask
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
    rsp_ready = 1'b0; prdata = 32'd0; pready = 1'b0; pselverr = 1'b0;
    step();
    step();
    chk("rst cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst psel", 32'(psel), 32'd0);
    chk("rst pen", 32'(pen), 32'd0);
    chk("rst paddr", paddr, 32'd0);
    chk("rst pwdata", pwdata, 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    chk("rst rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    step();
    chk("post-rst cmd_ready", 32'(cmd_ready), 32'd1);
    // write, pready high early (ignored in SETUP) -> rsp_valid at N+3
    pready = 1'b1; prdata = 32'hAAAA_5555;
    issue(1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("wr setup psel", 32'(psel), 32'd1);
    chk("wr setup pen", 32'(pen), 32'd0);
    chk("wr setup paddr", paddr, 32'h10);
    chk("wr setup wr_en", 32'(wr_en), 32'd1);
    chk("wr setup pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr setup cmd_ready", 32'(cmd_ready), 32'd0);
    chk("wr setup rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("wr access psel", 32'(psel), 32'd1);
    chk("wr access pen", 32'(pen), 32'd1);
    chk("wr access paddr", paddr, 32'h10);
    chk("wr access pwdata", pwdata, 32'hDEAD_BEEF);
    chk("wr access rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    pready = 1'b0;
    chk("wr resp rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr resp rsp_err", 32'(rsp_err), 32'd0);
    chk("wr resp rsp_rdata", rsp_rdata, 32'd0);
    chk("wr resp psel", 32'(psel), 32'd0);
    chk("wr resp pen", 32'(pen), 32'd0);
    chk("wr resp paddr", paddr, 32'd0);
    chk("wr resp cmd_ready", 32'(cmd_ready), 32'd0);
    release_rsp();
    // read with three wait states; fourth ACCESS cycle completes (also the watchdog-boundary case)
    issue(1'b0, 32'h10, 32'h1234_5678);
    chk("rd setup pwdata", pwdata, 32'd0);
    chk("rd setup wr_en", 32'(wr_en), 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("rd wait pen", 32'(pen), 32'd1);
      chk("rd wait psel", 32'(psel), 32'd1);
      chk("rd wait paddr", paddr, 32'h10);
      chk("rd wait wr_en", 32'(wr_en), 32'd0);
      chk("rd wait rsp_valid", 32'(rsp_valid), 32'd0);
      step();
    end
    chk("rd wait4 pen", 32'(pen), 32'd1);
    chk("rd wait4 rsp_valid", 32'(rsp_valid), 32'd0);
    pready = 1'b1; prdata = 32'hDEAD_BEEF;
    step();
    pready = 1'b0; prdata = 32'h0;
    chk("rd resp rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd resp rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd resp rsp_err", 32'(rsp_err), 32'd0);
    chk("rd resp rsp_timeout", 32'(rsp_timeout), 32'd0);
    step();
    chk("rd resp hold rdata", rsp_rdata, 32'hDEAD_BEEF);
    release_rsp();
    // misaligned read -> error response at N+1, no psel
    pready = 1'b1; prdata = 32'h7777_7777;
    issue(1'b0, 32'h13, 32'd0);
    chk("mis rsp_valid", 32'(rsp_valid), 32'd1);
    chk("mis rsp_err", 32'(rsp_err), 32'd1);
    chk("mis rsp_rdata", rsp_rdata, 32'd0);
    chk("mis psel", 32'(psel), 32'd0);
    step();
    chk("mis hold psel", 32'(psel), 32'd0);
    pready = 1'b0;
    release_rsp();
    // write with slave error, response held while rsp_ready low
    issue(1'b1, 32'h20, 32'hCAFE_F00D);
    step();
    pready = 1'b1; pselverr = 1'b1; prdata = 32'h1234;
    step();
    pready = 1'b0; pselverr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("slverr rsp_valid", 32'(rsp_valid), 32'd1);
      chk("slverr rsp_err", 32'(rsp_err), 32'd1);
      chk("slverr rsp_rdata", rsp_rdata, 32'd0);
      chk("slverr cmd_ready", 32'(cmd_ready), 32'd0);
      step();
    end
    release_rsp();
    // stalled read: aborts after 4 ACCESS cycles with the watchdog, waits otherwise
    issue(1'b0, 32'h24, 32'd0);
    step();
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      chk("to wait pen", 32'(pen), 32'd1);
      chk("to wait rsp_valid", 32'(rsp_valid), 32'd0);
      step();
    end
    step();
    chk("to rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to rsp_timeout", 32'(rsp_timeout), 32'd1);
    chk("to rsp_err", 32'(rsp_err), 32'd1);
    chk("to rsp_rdata", rsp_rdata, 32'd0);
    chk("to psel", 32'(psel), 32'd0);
    chk("to pen", 32'(pen), 32'd0);
`else
    for (int i = 0; i < 10; i++) begin
      chk("nto wait pen", 32'(pen), 32'd1);
      chk("nto wait rsp_valid", 32'(rsp_valid), 32'd0);
      step();
    end
    pready = 1'b1; prdata = 32'h55;
    step();
    pready = 1'b0;
    chk("nto rsp_valid", 32'(rsp_valid), 32'd1);
    chk("nto rsp_timeout", 32'(rsp_timeout), 32'd0);
    chk("nto rsp_rdata", rsp_rdata, 32'h55);
`endif
    release_rsp();
    chk("post-to rsp_timeout", 32'(rsp_timeout), 32'd0);
    // reset pulsed during ACCESS drops the transfer
    issue(1'b1, 32'h30, 32'h1111_2222);
    step();
    chk("rst-acc pen before", 32'(pen), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst-acc psel", 32'(psel), 32'd0);
    chk("rst-acc pen", 32'(pen), 32'd0);
    chk("rst-acc rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst-acc cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    chk("rst-acc cmd_ready after", 32'(cmd_ready), 32'd1);
    chk("rst-acc rsp_valid after", 32'(rsp_valid), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
